// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction fetch unit: FSM states, PC step and
// redirect target select encodings.
package instr_fetch_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned PC_STEP = 4;

  localparam logic SEL_BRANCH = 1'b0;
  localparam logic SEL_JUMP   = 1'b1;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    FULL = 2'd1,
    DROP = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_target_calc.sv
// Redirect target calculation: PC-relative branch or pseudo-direct jump.
module fetch_target_calc
  import instr_fetch_pkg::*;
(
  input  logic            sel,
  input  logic [XLEN-1:0] base_pc,
  input  logic [15:0]     imm16,
  input  logic [25:0]     jidx26,
  output logic [XLEN-1:0] target_c
);

  logic [XLEN-1:0] seq_pc;
  logic [XLEN-1:0] branch_off;

  // Both targets are relative to the instruction after the redirecting one
  always_comb begin
    seq_pc     = base_pc + XLEN'(PC_STEP);
    branch_off = {{14{imm16[15]}}, imm16, 2'b00};
    target_c   = seq_pc + branch_off;
    case (sel)
      SEL_BRANCH: target_c = seq_pc + branch_off;
      SEL_JUMP:   target_c = {seq_pc[31:28], jidx26, 2'b00};
      default:    target_c = seq_pc + branch_off;
    endcase
  end

endmodule

// File: rtl/instr_fetch.sv
// Single-outstanding-request instruction fetch unit with a one-entry output
// buffer and branch/jump redirect support.
// Optional performance counters (fetch_count, stall_count) are built when
// IFETCH_PERF_CNT_EN is defined.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
`ifdef IFETCH_PERF_CNT_EN
  output logic [31:0] fetch_count,
  output logic [31:0] stall_count,
`endif
  input  logic        instr_ready,
  input  logic        redirect_valid,
  input  logic        redirect_sel,
  input  logic [31:0] redirect_base_pc,
  input  logic [15:0] redirect_imm16,
  input  logic [25:0] redirect_jidx26
);

  fetch_state_t    state;
  fetch_state_t    state_next;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_next;
  logic [XLEN-1:0] target;
  logic            load_instr;

  fetch_target_calc u_target (
    .sel      (redirect_sel),
    .base_pc  (redirect_base_pc),
    .imm16    (redirect_imm16),
    .jidx26   (redirect_jidx26),
    .target_c (target)
  );

  // Request is live in REQ and DROP; forced low while reset is asserted
  assign imem_req = !reset && (state != FULL);

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= REQ;
    else       state <= state_next;
  end

  // Next-state, next-pc and buffer-load decisions
  always_comb begin
    state_next = state;
    pc_next    = pc;
    load_instr = 1'b0;
    case (state)
      REQ: begin
        if (imem_ack) begin
          if (redirect_valid) begin
            pc_next = target;
          end else begin
            load_instr = 1'b1;
            pc_next    = pc + XLEN'(PC_STEP);
            state_next = FULL;
          end
        end else if (redirect_valid) begin
          pc_next    = target;
          state_next = DROP;
        end
      end
      FULL: begin
        if (redirect_valid) begin
          pc_next    = target;
          state_next = REQ;
        end else if (instr_ready) begin
          state_next = REQ;
        end
      end
      DROP: begin
        if (redirect_valid) pc_next = target;
        if (imem_ack)       state_next = REQ;
      end
      default: state_next = REQ;
    endcase
  end

  // PC, request address and output buffer; the address is frozen while a
  // squashed request is still waiting for its ack
  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= RESET_PC;
      imem_addr   <= RESET_PC;
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
    end else begin
      pc <= pc_next;
      if (state_next != DROP) imem_addr <= pc_next;
      if (load_instr) begin
        instr    <= imem_rdata;
        instr_pc <= imem_addr;
      end
      instr_valid <= (state_next == FULL);
    end
  end

`ifdef IFETCH_PERF_CNT_EN
  // Delivered-instruction and decode-stall counters, wrapping at 2^32
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_count <= '0;
      stall_count <= '0;
    end else if (instr_valid) begin
      if (instr_ready) fetch_count <= fetch_count + 32'd1;
      else             stall_count <= stall_count + 32'd1;
    end
  end
`endif

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the first fetch address after reset.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 reset  input  1  SHALL be the synchronous, active-high reset.
REQ-004 imem_req  output  1  SHALL mean the memory read request is valid.
REQ-005 imem_addr  output  32  SHALL be the word address of the request; stable while imem_req=1 and imem_ack=0.
REQ-006 imem_ack  input  1  SHALL mean imem_rdata is valid this cycle; it may assert in the same cycle as imem_req.
REQ-007 imem_rdata  input  32  SHALL be the instruction word returned.
REQ-008 instr  output  32  SHALL be the buffered instruction word for the decode stage.
REQ-009 instr_pc  output  32  SHALL be the address instr was fetched from.
REQ-010 instr_valid  output  1  SHALL mean instr/instr_pc are valid.
REQ-011 instr_ready  input  1  SHALL mean decode accepts instr this cycle.
REQ-012 redirect_valid  input  1  SHALL request a PC change this cycle.
REQ-013 redirect_sel  input  1  SHALL select the target: 0 branch, 1 jump.
REQ-014 redirect_base_pc  input  32  SHALL be the PC of the redirecting instruction.
REQ-015 redirect_imm16  input  16  SHALL be the branch offset field.
REQ-016 redirect_jidx26  input  26  SHALL be the jump index field.

Function
REQ-017 FSM SHALL have states REQ, FULL, DROP, with at most one outstanding memory request.
REQ-018 Branch target SHALL be redirect_base_pc+4+(sign-extended imm16<<2), mod 2^32. Jump target SHALL be {(redirect_base_pc+4)[31:28], jidx26, 2'b00}.
REQ-019 REQ: imem_req=1, imem_addr=pc. If ack and no redirect, then instr<=rdata, instr_pc<=pc, pc<=pc+4 (wraps at 2^32), instr_valid<=1, next state FULL.
REQ-020 REQ with ack and redirect SHALL discard rdata, set pc<=target, and stay in REQ.
REQ-021 REQ with no ack and redirect SHALL set pc<=target and go to DROP; imem_addr SHALL keep the old request address.
REQ-022 DROP: imem_req=1 with the old address; on ack, rdata SHALL be discarded and the next state is REQ at the new pc. A further redirect in DROP SHALL overwrite pc; the last redirect wins.
REQ-023 FULL: imem_req=0, instr_valid=1, instr/instr_pc held. On instr_ready, instr_valid<=0 and the next state is REQ.
REQ-024 FULL with redirect SHALL clear instr_valid, set pc<=target, and go to REQ. If instr_ready is also high, the transfer still counts as completed.
REQ-025 Latency SHALL be: request issued the first cycle in REQ; instr_valid one cycle after ack. Peak throughput is one instruction per 2 cycles with a zero-wait memory.
REQ-026 instr_valid SHALL never assert for data fetched from a squashed address.

Reset
REQ-027 Under reset: state=REQ, pc=RESET_PC, instr=0, instr_pc=0, instr_valid=0, and the performance counters are 0. imem_req SHALL be 0 during the reset cycle.
REQ-028 Reset mid-request SHALL abandon the request without waiting for ack; the memory is required to tolerate this.

Configuration
REQ-029 With IFETCH_PERF_CNT_EN defined, the block SHALL add output fetch_count[31:0] and output stall_count[31:0].
- fetch_count increments on each instr_valid&&instr_ready.
- stall_count increments on each cycle with instr_valid&&!instr_ready.
- Both wrap at 2^32.
Without the macro, these ports and counters SHALL be absent.

Structure
REQ-030 A shared package SHALL hold the FSM state enum (REQ, FULL, DROP), the PC_STEP=4 constant, and the redirect_sel encodings (SEL_BRANCH=0, SEL_JUMP=1).
REQ-031 Target arithmetic SHALL live in a combinational sub-module, fetch_target_calc, instantiated once.

Verification
REQ-032 Reset, zero-wait memory, instr_ready=1 -> addresses 0x0, 0x4, 0x8 are requested, and instr_valid pulses every 2nd cycle with matching instr_pc.
REQ-033 Branch at base 0x100, imm16=0xFFFF, issued while in REQ with ack=0 -> DROP is entered. The late ack data is never shown, and the next imem_addr is 0x100.
REQ-034 Jump at base 0xF000_0010, jidx26=0x0000040 -> the next imem_addr is 0xF000_0100.
REQ-035 instr_ready held 0 for 5 cycles in FULL -> instr and instr_pc are stable, and imem_req stays 0. With IFETCH_PERF_CNT_EN defined, stall_count=5.
REQ-036 Redirect and instr_ready in the same FULL cycle -> the transfer is counted, instr_valid is 0 the next cycle, and the target is fetched next.
REQ-037 pc=0xFFFF_FFFC fetched -> the next pc is 0x0000_0000. Reset asserted while in DROP -> the next request is at RESET_PC.
